i2s_phy_out: RTL and testbench

//  I2S/TDM serializer to a DAC; the transmit counterpart of i2s_phy_in. Takes an 8-bit AXI-Stream of
//  MSB-first sample bytes and shifts them out on datao in bclk slots aligned to lrck frame starts.
//  One instance per channel, fed by the same parsed-register and enable-sync logic as the input path.
//  Top level drives bclk inverted, so posedge launches land on the pad's falling edge.

---
 rtl/i2s_phy_out.sv | 208 ++++++++++++++++++++
 tb/tb_i2s_phy_out.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_phy_out.sv
// I2S/TDM transmit serializer: MSB-first sample bytes from an 8-bit stream are shifted onto datao
// in bclk slots aligned to lrck frame starts, with zero fill, underrun and sync-error accounting.
module i2s_phy_out (
  input  logic        bclk,
  input  logic        rst,
  input  logic        lrck,
  output logic        datao,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic [4:0]  i_tdm_num,
  input  logic [5:0]  i_word_width,
  input  logic [5:0]  i_valid_word_width,
  input  logic        i_lrck_polarity,
  input  logic        i_lrck_alignment,
  input  logic        i_enable,
  output logic [31:0] o_frame_num,
  output logic [15:0] o_underrun_cnt,
  output logic [15:0] o_sync_err_cnt
);

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BIT_W    = 6;
  localparam int unsigned SLOT_W   = 5;

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, SHIFT, PAD} state_t;

  state_t              state_q, state_n;
  logic                lrck_d, pend_q, pend_n;
  logic [SLOT_W-1:0]   cfg_tdm_q, cfg_tdm_n;
  logic [BIT_W-1:0]    cfg_ww_q, cfg_ww_n, cfg_vww_q, cfg_vww_n;
  logic                cfg_pol_q, cfg_pol_n, cfg_align_q, cfg_align_n;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_n;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_n, in_slot_q, in_slot_n;
  logic [SAMPLE_W-1:0] shift_q, shift_n, next_q, next_n;
  logic                next_full_q, next_full_n;
  logic [1:0]          byte_cnt_q, byte_cnt_n;
  logic                datao_n, tready_n;
  logic [FRAME_W-1:0]  frame_n;
  logic [CNT_W-1:0]    underrun_n, sync_err_n;

  logic       start_c, launch_c, last_bit_c, last_slot_c, accept_c, last_byte_c, slot_start_c;
  logic [1:0] bytes_m1_c;

  // Frame start on the configured lrck edge; alignment 1 launches slot 0 one bclk later
  assign start_c     = cfg_pol_q ? (~lrck & lrck_d) : (lrck & ~lrck_d);
  assign launch_c    = (start_c & ~cfg_align_q) | pend_q;
  assign last_bit_c  = (bit_cnt_q == cfg_ww_q - 6'd1);
  assign last_slot_c = (slot_cnt_q == cfg_tdm_q - 5'd1);
  assign accept_c    = s_axis_tvalid & s_axis_tready;
  assign bytes_m1_c  = 2'(cfg_vww_q[5:3] - 3'd1);
  assign last_byte_c = (byte_cnt_q == bytes_m1_c);

  always_comb begin
    state_n      = state_q;
    pend_n       = 1'b0;
    cfg_tdm_n    = cfg_tdm_q;
    cfg_ww_n     = cfg_ww_q;
    cfg_vww_n    = cfg_vww_q;
    cfg_pol_n    = cfg_pol_q;
    cfg_align_n  = cfg_align_q;
    bit_cnt_n    = bit_cnt_q;
    slot_cnt_n   = slot_cnt_q;
    shift_n      = shift_q;
    next_n       = next_q;
    next_full_n  = next_full_q;
    byte_cnt_n   = byte_cnt_q;
    in_slot_n    = in_slot_q;
    datao_n      = 1'b0;
    frame_n      = o_frame_num;
    underrun_n   = o_underrun_cnt;
    sync_err_n   = o_sync_err_cnt;
    slot_start_c = 1'b0;

    // Configuration tracks the inputs only while no frame is being shifted
    if (state_q != SHIFT) begin
      cfg_tdm_n   = i_tdm_num;
      cfg_ww_n    = i_word_width;
      cfg_vww_n   = i_valid_word_width;
      cfg_pol_n   = i_lrck_polarity;
      cfg_align_n = i_lrck_alignment;
    end

    if (!i_enable) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      slot_cnt_n  = '0;
      shift_n     = '0;
      next_n      = '0;
      next_full_n = 1'b0;
      byte_cnt_n  = '0;
      in_slot_n   = '0;
    end else if (state_q == IDLE) begin
      state_n = WAIT_SYNC;
    end else begin
      if (start_c) begin
        frame_n = o_frame_num + 32'd1;
        pend_n  = cfg_align_q;
        // A delayed-launch start coinciding with the final bit is an on-time frame
        if (state_q == SHIFT && !(cfg_align_q && last_bit_c && last_slot_c))
          sync_err_n = (&o_sync_err_cnt) ? o_sync_err_cnt : o_sync_err_cnt + 16'd1;
      end

      if (launch_c) begin
        state_n      = SHIFT;
        slot_start_c = 1'b1;
        bit_cnt_n    = 6'd1;
        slot_cnt_n   = '0;
      end else if (state_q == SHIFT) begin
        if (bit_cnt_q == '0) begin
          slot_start_c = 1'b1;
        end else begin
          datao_n = (bit_cnt_q < cfg_vww_q) & shift_q[SAMPLE_W-1];
          shift_n = {shift_q[SAMPLE_W-2:0], 1'b0};
        end
        if (last_bit_c) begin
          bit_cnt_n = '0;
          if (last_slot_c) state_n = PAD;
          else             slot_cnt_n = slot_cnt_q + 5'd1;
        end else begin
          bit_cnt_n = bit_cnt_q + 6'd1;
        end
      end

      // Slot boundary: take the buffered sample or send a zero slot
      if (slot_start_c) begin
        if (next_full_q) begin
          datao_n     = next_q[SAMPLE_W-1];
          shift_n     = {next_q[SAMPLE_W-2:0], 1'b0};
          next_full_n = 1'b0;
        end else begin
          shift_n    = '0;
          underrun_n = (&o_underrun_cnt) ? o_underrun_cnt : o_underrun_cnt + 16'd1;
        end
      end

      if (accept_c) begin
        case (byte_cnt_q)
          2'd0:    next_n[31:24] = s_axis_tdata;
          2'd1:    next_n[23:16] = s_axis_tdata;
          2'd2:    next_n[15:8]  = s_axis_tdata;
          default: next_n[7:0]   = s_axis_tdata;
        endcase
        if (last_byte_c) begin
          byte_cnt_n  = '0;
          next_full_n = 1'b1;
          in_slot_n   = last_slot_c ? in_slot_q : in_slot_q;
          in_slot_n   = (in_slot_q == cfg_tdm_q - 5'd1) ? '0 : in_slot_q + 5'd1;
        end else begin
          byte_cnt_n = byte_cnt_q + 2'd1;
        end
        if (s_axis_tlast) in_slot_n = '0;
      end
    end

    tready_n = ~next_full_n;
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q        <= IDLE;
      lrck_d         <= 1'b0;
      pend_q         <= 1'b0;
      cfg_tdm_q      <= '0;
      cfg_ww_q       <= '0;
      cfg_vww_q      <= '0;
      cfg_pol_q      <= 1'b0;
      cfg_align_q    <= 1'b0;
      bit_cnt_q      <= '0;
      slot_cnt_q     <= '0;
      shift_q        <= '0;
      next_q         <= '0;
      next_full_q    <= 1'b0;
      byte_cnt_q     <= '0;
      in_slot_q      <= '0;
      datao          <= 1'b0;
      s_axis_tready  <= 1'b0;
      o_frame_num    <= '0;
      o_underrun_cnt <= '0;
      o_sync_err_cnt <= '0;
    end else begin
      state_q        <= state_n;
      lrck_d         <= lrck;
      pend_q         <= pend_n;
      cfg_tdm_q      <= cfg_tdm_n;
      cfg_ww_q       <= cfg_ww_n;
      cfg_vww_q      <= cfg_vww_n;
      cfg_pol_q      <= cfg_pol_n;
      cfg_align_q    <= cfg_align_n;
      bit_cnt_q      <= bit_cnt_n;
      slot_cnt_q     <= slot_cnt_n;
      shift_q        <= shift_n;
      next_q         <= next_n;
      next_full_q    <= next_full_n;
      byte_cnt_q     <= byte_cnt_n;
      in_slot_q      <= in_slot_n;
      datao          <= datao_n;
      s_axis_tready  <= tready_n;
      o_frame_num    <= frame_n;
      o_underrun_cnt <= underrun_n;
      o_sync_err_cnt <= sync_err_n;
    end
  end

endmodule

// File: tb/tb_i2s_phy_out.sv
// Scoreboard bench for i2s_phy_out: expected slot words are queued with the stream bytes and
// compared against slot words reassembled from datao.
module tb_i2s_phy_out;

  logic        bclk = 1'b0;
  logic        rst = 1'b1;
  logic        lrck = 1'b1;
  logic        datao;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic [4:0]  tdm_num;
  logic [5:0]  word_width, valid_word_width;
  logic        lrck_polarity, lrck_alignment, enable;
  logic [31:0] frame_num;
  logic [15:0] underrun_cnt, sync_err_cnt;

  logic        bits_q[$];
  logic [8:0]  byte_q[$];
  logic [31:0] exp_q[$];
  logic        hs;
  int          n_checks = 0;
  int          n_errors = 0;
  int          ww_cur, vww_cur, align_cur;

  i2s_phy_out dut (
    .bclk(bclk), .rst(rst), .lrck(lrck), .datao(datao),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .i_tdm_num(tdm_num), .i_word_width(word_width), .i_valid_word_width(valid_word_width),
    .i_lrck_polarity(lrck_polarity), .i_lrck_alignment(lrck_alignment), .i_enable(enable),
    .o_frame_num(frame_num), .o_underrun_cnt(underrun_cnt), .o_sync_err_cnt(sync_err_cnt)
  );

  always #5 bclk = ~bclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte stream driver: pop a byte once the previous posedge saw a handshake
  always @(posedge bclk) hs <= s_axis_tvalid & s_axis_tready;

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge bclk);
      if (hs === 1'b1 && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0) begin
        s_axis_tvalid = 1'b1;
        {s_axis_tlast, s_axis_tdata} = byte_q[0];
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
    end
  end

  task automatic set_cfg(input int tdm, input int ww, input int vww, input bit pol, input bit al);
    tdm_num = 5'(tdm); word_width = 6'(ww); valid_word_width = 6'(vww);
    lrck_polarity = pol; lrck_alignment = al;
    ww_cur = ww; vww_cur = vww; align_cur = int'(al);
  endtask

  task automatic queue_sample(input logic [31:0] w, input bit last, input bit track);
    int nb;
    logic [31:0] mask;
    nb = vww_cur / 8;
    for (int b = 0; b < nb; b++)
      byte_q.push_back({last && (b == nb - 1), 8'(w >> (8 * (nb - 1 - b)))});
    mask = (vww_cur == 32) ? 32'hFFFF_FFFF : ((32'd1 << vww_cur) - 32'd1);
    if (track) exp_q.push_back((w & mask) << (ww_cur - vww_cur));
  endtask

  task automatic tick(input logic v);
    @(negedge bclk);
    bits_q.push_back(datao);
    lrck = v;
  endtask

  task automatic run_frames(input int n, input int len, input logic start_lvl, input int extra);
    for (int i = 0; i < n * len; i++) tick(((i % len) < len / 2) ? start_lvl : ~start_lvl);
    repeat (extra) tick(~start_lvl);
  endtask

  function automatic logic [31:0] get_word(input int base, input int n);
    logic [31:0] w = '0;
    if (base + n > bits_q.size()) return 32'hDEAD_BEEF;
    for (int k = 0; k < n; k++) w = {w[30:0], bits_q[base + k]};
    return w;
  endfunction

  // Frame whose start edge was driven at tick t0: bit j is sampled at tick t0+1+align+j
  task automatic compare_frame(input string tag, input int t0, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      if (exp_q.size() == 0) check($sformatf("%s_s%0d_noexp", tag, s), 32'd1, 32'd0);
      else check($sformatf("%s_s%0d", tag, s),
                 get_word(t0 + 1 + align_cur + s * ww_cur, ww_cur), exp_q.pop_front());
    end
  endtask

  initial begin
    logic v;
    logic [31:0] e;
    int ones;
    set_cfg(2, 32, 24, 1'b1, 1'b1);
    enable = 1'b0;
    repeat (3) tick(1'b1);
    check("rst_datao", 32'(datao), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_frame", frame_num, 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_syncerr", 32'(sync_err_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) tick(1'b1);
    enable = 1'b1;
    repeat (2) tick(1'b1);

    // Stereo I2S, falling-edge start, MSB one bclk late, 24 of 32 bits
    queue_sample(32'h00A1B2C3, 1'b0, 1'b1);
    queue_sample(32'h00445566, 1'b1, 1'b1);
    queue_sample(32'h00123456, 1'b0, 1'b1);
    queue_sample(32'h00789ABC, 1'b1, 1'b1);
    repeat (12) tick(1'b1);
    bits_q.delete();
    run_frames(2, 64, 1'b0, 4);
    compare_frame("t1f0", 0, 2);
    compare_frame("t1f1", 64, 2);
    check("t1_frame", frame_num, 32'd2);
    check("t1_underrun", 32'(underrun_cnt), 32'd0);

    // TDM8, 16-bit slots, rising-edge start, preloaded stream
    set_cfg(8, 16, 16, 1'b0, 1'b0);
    repeat (3) tick(1'b1);
    repeat (3) tick(1'b0);
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 8; s++) queue_sample($urandom, s == 7, 1'b1);
    repeat (12) tick(1'b0);
    bits_q.delete();
    run_frames(2, 128, 1'b1, 4);
    compare_frame("t2f0", 0, 8);
    compare_frame("t2f1", 128, 8);
    check("t2_frame", frame_num, 32'd4);
    check("t2_underrun", 32'(underrun_cnt), 32'd0);

    // Starvation after slot 2, data returns just before the next frame
    for (int s = 0; s < 3; s++) queue_sample($urandom, 1'b0, 1'b1);
    repeat (5) exp_q.push_back(32'd0);
    repeat (12) tick(1'b0);
    bits_q.delete();
    fork
      run_frames(2, 128, 1'b1, 4);
      begin
        repeat (115) @(negedge bclk);
        for (int s = 0; s < 8; s++) queue_sample($urandom, s == 7, 1'b1);
      end
    join
    compare_frame("t3f0", 0, 8);
    compare_frame("t3f1", 128, 8);
    check("t3_underrun", 32'(underrun_cnt), 32'd5);
    check("t3_frame", frame_num, 32'd6);

    // Early frame start in the middle of slot 1
    for (int s = 0; s < 10; s++) queue_sample($urandom, s == 7, 1'b1);
    repeat (12) tick(1'b0);
    bits_q.delete();
    for (int g = 0; g < 156; g++) begin
      if (g < 20) v = 1'b1;
      else if (g < 24) v = 1'b0;
      else if (g < 88) v = 1'b1;
      else v = 1'b0;
      tick(v);
    end
    check("t4_s0", get_word(1, 16), exp_q.pop_front());
    e = exp_q.pop_front();
    check("t4_s1_part", get_word(17, 8), e >> 8);
    compare_frame("t4r", 24, 8);
    check("t4_syncerr", 32'(sync_err_cnt), 32'd1);
    check("t4_frame", frame_num, 32'd8);
    check("t4_underrun", 32'(underrun_cnt), 32'd5);

    // Disable mid-slot, stay quiet while disabled, resume on a later frame start
    for (int s = 0; s < 8; s++) queue_sample($urandom, s == 7, 1'b0);
    repeat (12) tick(1'b0);
    bits_q.delete();
    for (int g = 0; g < 388; g++) begin
      tick((g < 384) ? ((g % 128) < 64) : 1'b0);
      if (g == 40) enable = 1'b0;
      if (g == 41) begin
        check("t5_datao_off", 32'(bits_q[41]), 32'd0);
        check("t5_tready_off", 32'(s_axis_tready), 32'd1);
      end
      if (g == 200) enable = 1'b1;
      if (g == 210)
        for (int s = 0; s < 8; s++) queue_sample($urandom, s == 7, 1'b1);
    end
    ones = 0;
    for (int k = 41; k <= 256; k++) if (bits_q[k] === 1'b1) ones++;
    check("t5_idle_quiet", 32'(ones), 32'd0);
    compare_frame("t5f", 256, 8);
    check("t5_frame", frame_num, 32'd10);
    check("t5_underrun", 32'(underrun_cnt), 32'd5);
    check("t5_syncerr", 32'(sync_err_cnt), 32'd1);

    // Reset in the middle of a frame
    for (int s = 0; s < 8; s++) queue_sample($urandom, s == 7, 1'b0);
    repeat (12) tick(1'b0);
    bits_q.delete();
    for (int g = 0; g < 40; g++) begin
      tick((g % 128) < 64);
      if (g == 30) begin
        rst = 1'b1;
        byte_q.delete();
      end
      if (g == 31) begin
        check("t6_datao", 32'(bits_q[31]), 32'd0);
        check("t6_tready", 32'(s_axis_tready), 32'd0);
        check("t6_frame", frame_num, 32'd0);
        check("t6_underrun", 32'(underrun_cnt), 32'd0);
        check("t6_syncerr", 32'(sync_err_cnt), 32'd0);
      end
      if (g == 33) rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
